// File: rtl/matmul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_sequencer
//  Description : Control-only scheduler for an N x N matrix product C = A*B.
//                Walks i, j, k in row-major order, issues operand read
//                addresses, drives the MAC clear/accumulate enables and the
//                result write strobe/address, then pulses done.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   clock, rising edge
//    rst      in   asynchronous active-high reset
//    start    in   begin a multiplication (sampled only in IDLE)
//    abort    in   synchronous cancel, any state (wins over start)
//    busy     out  high in RUN and DRAIN
//    done     out  one-cycle completion pulse
//    rd_en    out  operand memory read enable
//    a_addr   out  A address = i*N + k
//    b_addr   out  B address = k*N + j
//    mac_en   out  MAC consumes operand data this cycle
//    mac_clr  out  with mac_en: load product instead of accumulating
//    c_we     out  result write strobe
//    c_addr   out  C address = i*N + j of the element being written
// ============================================================================
module matmul_sequencer #(
    parameter int N  = 4,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic          mac_en,
    output logic          mac_clr,
    output logic          c_we,
    output logic [AW-1:0] c_addr
);

    localparam int              CW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]   IDX_LAST = CW'(N - 1);
    localparam logic [AW-1:0]   N_AW   = AW'(N);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] i_q, i_d;
    logic [CW-1:0] j_q, j_d;
    logic [CW-1:0] k_q, k_d;
    logic          drain_q, drain_d;

    // Pipeline registers: stage 1 aligns with operand data, stage 2 with
    // the registered accumulator output.
    logic          mac_en_q;
    logic          mac_clr_q;
    logic          last_q;
    logic [AW-1:0] ij_q;
    logic          c_we_q;
    logic [AW-1:0] c_addr_q;

    logic          run_active;
    logic [AW-1:0] i_ext, j_ext, k_ext;

    assign run_active = (state_q == ST_RUN);
    assign i_ext      = AW'(i_q);
    assign j_ext      = AW'(j_q);
    assign k_ext      = AW'(k_q);

    // ------------------------------------------------------------------
    // State and loop counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        drain_d = drain_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            ST_RUN: begin
                if (k_q == IDX_LAST) begin
                    k_d = '0;
                    if (j_q == IDX_LAST) begin
                        j_d = '0;
                        if (i_q == IDX_LAST) begin
                            i_d     = '0;
                            state_d = ST_DRAIN;
                            drain_d = 1'b0;
                        end else begin
                            i_d = i_q + CW'(1);
                        end
                    end else begin
                        j_d = j_q + CW'(1);
                    end
                end else begin
                    k_d = k_q + CW'(1);
                end
            end
            ST_DRAIN: begin
                // Two cycles: one for the MAC to absorb the last operands,
                // one for the final C write.
                if (drain_q) begin
                    drain_d = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d = ST_IDLE;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            drain_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // MAC / write-back pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_en_q  <= 1'b0;
            mac_clr_q <= 1'b0;
            last_q    <= 1'b0;
            ij_q      <= '0;
            c_we_q    <= 1'b0;
            c_addr_q  <= '0;
        end else if (abort) begin
            mac_en_q  <= 1'b0;
            mac_clr_q <= 1'b0;
            last_q    <= 1'b0;
            ij_q      <= '0;
            c_we_q    <= 1'b0;
            c_addr_q  <= '0;
        end else begin
            mac_en_q  <= run_active;
            mac_clr_q <= run_active && (k_q == '0);
            last_q    <= run_active && (k_q == IDX_LAST);
            ij_q      <= i_ext * N_AW + j_ext;
            c_we_q    <= mac_en_q && last_q;
            c_addr_q  <= ij_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done    = (state_q == ST_DONE);
    assign rd_en   = run_active;
    assign a_addr  = i_ext * N_AW + k_ext;
    assign b_addr  = k_ext * N_AW + j_ext;
    assign mac_en  = mac_en_q;
    assign mac_clr = mac_clr_q;
    assign c_we    = c_we_q;
    assign c_addr  = c_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_matmul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matmul_sequencer
//  Description : Self-checking bench for matmul_sequencer. Three instances
//                (N = 2, 3, 4) share clock and reset. Operand memories and a
//                MAC are modelled here; expected read addresses, C addresses
//                and C data are queued when a run is launched and popped as
//                the sequencer produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_sequencer;

    localparam int AW = 8;
    localparam int ND = 3;   // instance d has N = d + 2

    logic          clk;
    logic          rst;
    logic          start_s   [ND];
    logic          abort_s   [ND];
    logic          busy_s    [ND];
    logic          done_s    [ND];
    logic          rd_en_s   [ND];
    logic [AW-1:0] a_addr_s  [ND];
    logic [AW-1:0] b_addr_s  [ND];
    logic          mac_en_s  [ND];
    logic          mac_clr_s [ND];
    logic          c_we_s    [ND];
    logic [AW-1:0] c_addr_s  [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        matmul_sequencer #(.N(g + 2), .AW(AW)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start_s[g]),
            .abort   (abort_s[g]),
            .busy    (busy_s[g]),
            .done    (done_s[g]),
            .rd_en   (rd_en_s[g]),
            .a_addr  (a_addr_s[g]),
            .b_addr  (b_addr_s[g]),
            .mac_en  (mac_en_s[g]),
            .mac_clr (mac_clr_s[g]),
            .c_we    (c_we_s[g]),
            .c_addr  (c_addr_s[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Operand memories (1-cycle read latency) and registered MAC
    logic [7:0]  amem [ND][256];
    logic [7:0]  bmem [ND][256];
    logic [7:0]  ad   [ND];
    logic [7:0]  bd   [ND];
    int unsigned acc  [ND];

    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (rd_en_s[d]) begin
                ad[d] <= amem[d][a_addr_s[d]];
                bd[d] <= bmem[d][b_addr_s[d]];
            end
            if (mac_en_s[d]) begin
                acc[d] <= mac_clr_s[d] ? (32'(ad[d]) * 32'(bd[d]))
                                       : (acc[d] + 32'(ad[d]) * 32'(bd[d]));
            end
        end
    end

    // Scoreboard
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [15:0] q_rd    [$];
    int unsigned q_caddr [$];
    int unsigned q_cdata [$];

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned got_flags(input int d);
        return {26'd0, rd_en_s[d], mac_en_s[d], mac_clr_s[d], c_we_s[d], busy_s[d], done_s[d]};
    endfunction

    // Expected {rd_en, mac_en, mac_clr, c_we, busy, done} in cycle c after start
    function automatic int unsigned exp_flags(input int n, input int c);
        int  n3 = n * n * n;
        logic rd, me, clr, we, bz, dn;
        rd  = (c >= 1) && (c <= n3);
        me  = (c >= 2) && (c <= n3 + 1);
        clr = me && (((c - 2) % n) == 0);
        we  = (c >= n + 2) && (c <= n3 + 2) && (((c - 2) % n) == 0);
        bz  = (c >= 1) && (c <= n3 + 2);
        dn  = (c == n3 + 3);
        return {26'd0, rd, me, clr, we, bz, dn};
    endfunction

    // One full run on instance d. Called at a negedge with the DUT idle.
    // abort_cyc / pulse_cyc = 0 disables that event.
    task automatic run_seq(input int d, input int n, input int abort_cyc, input int pulse_cyc);
        int n3 = n * n * n;
        int cnt_rd = 0, cnt_me = 0, cnt_clr = 0, cnt_we = 0, done_cyc = 0;
        int unsigned sum;
        logic [15:0] ab;

        for (int x = 0; x < n * n; x++) begin
            amem[d][x] = 8'($urandom_range(0, 255));
            bmem[d][x] = 8'($urandom_range(0, 255));
        end
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                sum = 0;
                for (int k = 0; k < n; k++) begin
                    q_rd.push_back({8'(i * n + k), 8'(k * n + j)});
                    sum += 32'(amem[d][i * n + k]) * 32'(bmem[d][k * n + j]);
                end
                q_caddr.push_back(i * n + j);
                q_cdata.push_back(sum);
            end

        start_s[d] = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= n3 + 4; c++) begin
            @(negedge clk);
            check("flags", got_flags(d),
                  (abort_cyc > 0 && c > abort_cyc) ? 0 : exp_flags(n, c));
            if (rd_en_s[d]) begin
                cnt_rd++;
                if (q_rd.size() > 0) begin
                    ab = q_rd.pop_front();
                    check("rd_addr", {a_addr_s[d], b_addr_s[d]}, ab);
                end
            end
            if (mac_en_s[d])  cnt_me++;
            if (mac_clr_s[d]) cnt_clr++;
            if (done_s[d])    done_cyc = c;
            if (c_we_s[d]) begin
                cnt_we++;
                if (q_caddr.size() > 0) begin
                    check("c_addr", c_addr_s[d], q_caddr.pop_front());
                    check("c_data", acc[d], q_cdata.pop_front());
                end
            end
            if (c == 1)             start_s[d] = 1'b0;
            if (c == pulse_cyc)     start_s[d] = 1'b1;
            if (c == pulse_cyc + 1) start_s[d] = 1'b0;
            if (c == abort_cyc)     abort_s[d] = 1'b1;
            if (c == abort_cyc + 1) abort_s[d] = 1'b0;
        end
        start_s[d] = 1'b0;
        abort_s[d] = 1'b0;

        if (abort_cyc == 0) begin
            check("cnt_rd",   cnt_rd,   n3);
            check("cnt_mac",  cnt_me,   n3);
            check("cnt_clr",  cnt_clr,  n * n);
            check("cnt_cwe",  cnt_we,   n * n);
            check("done_cyc", done_cyc, n3 + 3);
            check("q_left",   q_rd.size() + q_caddr.size(), 0);
        end else begin
            check("abort_done", done_cyc, 0);
            q_rd.delete();
            q_caddr.delete();
            q_cdata.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < ND; d++) begin
            check(tag, got_flags(d), 0);
            check(tag, {8'd0, a_addr_s[d], b_addr_s[d], c_addr_s[d]}, 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < ND; d++) begin
            start_s[d] = 1'b0;
            abort_s[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check_all_zero("reset_state");
        rst = 1'b0;
        @(negedge clk);

        // N=2 address order and C write timing
        run_seq(0, 2, 0, 0);
        // N=4 counts and start-to-done latency
        run_seq(2, 4, 0, 0);
        // N=3 functional with random operands
        for (int r = 0; r < 10; r++) run_seq(1, 3, 0, 0);

        // start held high: repeating runs with a period of N^3 + 4
        start_s[0] = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            check("held_flags", got_flags(0), exp_flags(2, (c - 1) % 12 + 1));
            if (c == 36) start_s[0] = 1'b0;
        end

        // start pulses mid-RUN and during DONE are ignored
        run_seq(2, 4, 0, 20);
        run_seq(2, 4, 0, 67);

        // abort in cycle 10, then a clean full run
        run_seq(2, 4, 10, 0);
        run_seq(2, 4, 0, 0);

        // asynchronous reset mid-RUN
        start_s[2] = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) start_s[2] = 1'b0;
        end
        check("pre_rst_busy", {31'd0, busy_s[2]}, 1);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) check("idle_after_rst", got_flags(d), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
